// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: performs load/store over a req/ack handshake, writes the
// register file, holds the architectural flags, and flags memory time-outs and illegal ops.
module mem_wb_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_flags,
  input  logic [REG_AW-1:0] in_dst_reg,
  input  logic [DATA_W-1:0] in_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        flags_q,
  output logic              err_timeout,
  output logic              err_illegal
);

  typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, WB} state_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_INV   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_NOP   = 3'b100;

  // Abort is taken on the un-acked cycle whose increment would reach TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  // data_q holds the ALU result, then the memory address, then the load data.
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [REG_AW-1:0]   dst_q, dst_d;
  logic [3:0]          flags_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_illegal_q, err_illegal_d;
  logic                accept;

  assign accept      = in_valid & in_ready;
  assign err_timeout = err_timeout_q;
  assign err_illegal = err_illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      data_q        <= '0;
      wdata_q       <= '0;
      dst_q         <= '0;
      flags_q       <= '0;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      wdata_q       <= wdata_d;
      dst_q         <= dst_d;
      flags_q       <= flags_d;
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    wdata_d       = wdata_q;
    dst_d         = dst_q;
    flags_d       = flags_q;
    cnt_d         = cnt_q;
    err_timeout_d = err_timeout_q;
    err_illegal_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (in_op)
            OP_ADD, OP_INV: begin
              flags_d = in_flags;
              data_d  = in_result;
              dst_d   = in_dst_reg;
              state_d = WB;
            end
            OP_LOAD: begin
              data_d  = in_result;
              dst_d   = in_dst_reg;
              cnt_d   = '0;
              state_d = MEM_RD;
            end
            OP_STORE: begin
              data_d  = in_result;
              wdata_d = in_store_data;
              cnt_d   = '0;
              state_d = MEM_WR;
            end
            OP_NOP: begin
            end
            default: err_illegal_d = 1'b1;
          endcase
        end
      end

      MEM_RD, MEM_WR: begin
        // An ack on the last allowed cycle takes priority over the abort.
        if (mem_ack) begin
          if (state_q == MEM_RD) begin
            data_d  = mem_rdata;
            state_d = WB;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TO_LAST) begin
            state_d       = IDLE;
            err_timeout_d = 1'b1;
          end
        end
      end

      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state so reset removes a request immediately.
  always_comb begin
    in_ready  = (state_q == IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    case (state_q)
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = data_q;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = data_q;
        mem_wdata = wdata_q;
      end
      WB: begin
        rf_we    = 1'b1;
        rf_waddr = dst_q;
        rf_wdata = data_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: vector table of single instructions with a memory responder,
// scoreboard queues for register writes and memory transactions, plus a mid-load reset.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_result;
  logic [3:0]  in_flags;
  logic [2:0]  in_dst_reg;
  logic [15:0] in_store_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [3:0]  flags_q;
  logic        err_timeout;
  logic        err_illegal;

  mem_wb_stage #(.DATA_W(16), .REG_AW(3), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_result(in_result), .in_flags(in_flags), .in_dst_reg(in_dst_reg),
    .in_store_data(in_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flags_q(flags_q), .err_timeout(err_timeout), .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } rf_exp_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] res;
    logic [3:0]  fl;
    logic [2:0]  dst;
    logic [15:0] sd;
    int          ack_wait;   // req cycle index that gets the ack; -1 never acks
    logic [15:0] rd;
    int          exp_req;
    int          exp_busy;
    logic [3:0]  exp_flags;
    logic        exp_ill;
    logic        exp_to;
  } vec_t;

  rf_exp_t  rf_q[$];
  mem_exp_t mem_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor, sampling 1 time unit after each falling edge.
  always @(negedge clk) begin
    rf_exp_t  re;
    mem_exp_t me;
    #1;
    if (rf_we) begin
      if (rf_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rf_unexpected_write actual=%0h:%0h expected=none", rf_waddr, rf_wdata);
      end else begin
        re = rf_q.pop_front();
        chk("rf_waddr", 32'(rf_waddr), 32'(re.a));
        chk("rf_wdata", 32'(rf_wdata), 32'(re.d));
      end
    end else begin
      chk("rf_idle_zero", 32'({rf_waddr, rf_wdata}), 32'd0);
    end
    if (mem_req && mem_ack) begin
      if (mem_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_unexpected_xfer actual=%0h expected=none", mem_addr);
      end else begin
        me = mem_q.pop_front();
        chk("mem_we", 32'(mem_we), 32'(me.we));
        chk("mem_addr", 32'(mem_addr), 32'(me.addr));
        if (me.we) chk("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
      end
    end
    if (!mem_req) chk("mem_idle_zero", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
  end

  // Issues one instruction starting at a falling edge, responds to memory, returns at a
  // falling edge with the stage ready again.
  task automatic run_op(input vec_t v, output int req_cycles, output int busy_cycles,
                        output logic ill);
    in_valid      = 1'b1;
    in_op         = v.op;
    in_result     = v.res;
    in_flags      = v.fl;
    in_dst_reg    = v.dst;
    in_store_data = v.sd;
    case (v.op)
      3'b000, 3'b001: rf_q.push_back({v.dst, v.res});
      3'b010: if (v.ack_wait >= 0) begin
        mem_q.push_back({1'b0, v.res, 16'h0});
        rf_q.push_back({v.dst, v.rd});
      end
      3'b011: if (v.ack_wait >= 0) mem_q.push_back({1'b1, v.res, v.sd});
      default: begin
      end
    endcase
    @(posedge clk);
    @(negedge clk);
    in_valid      = 1'b0;
    in_op         = 3'($urandom);
    in_result     = 16'($urandom);
    in_flags      = 4'($urandom);
    in_dst_reg    = 3'($urandom);
    in_store_data = 16'($urandom);
    ill         = err_illegal;
    req_cycles  = 0;
    busy_cycles = 0;
    while (!in_ready && busy_cycles < 400) begin
      busy_cycles++;
      if (mem_req) begin
        if (req_cycles == v.ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rd;
        end
        req_cycles++;
      end
      @(posedge clk);
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
    end
    if (busy_cycles >= 400) chk("ready_wait_expired", 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[13];

  initial begin
    int   rq;
    int   bz;
    logic il;

    vecs[0]  = '{3'b000, 16'h8001, 4'b0100, 3'd3, 16'h0000,  0, 16'h0000, 0, 1, 4'b0100, 1'b0, 1'b0};
    vecs[1]  = '{3'b010, 16'h0040, 4'b1111, 3'd5, 16'h0000,  3, 16'hBEEF, 4, 5, 4'b0100, 1'b0, 1'b0};
    vecs[2]  = '{3'b011, 16'h1234, 4'b1111, 3'd0, 16'h00FF,  0, 16'h0000, 1, 1, 4'b0100, 1'b0, 1'b0};
    vecs[3]  = '{3'b110, 16'h0000, 4'b1111, 3'd1, 16'h0000,  0, 16'h0000, 0, 0, 4'b0100, 1'b1, 1'b0};
    vecs[4]  = '{3'b100, 16'hFFFF, 4'b1111, 3'd2, 16'h0000,  0, 16'h0000, 0, 0, 4'b0100, 1'b0, 1'b0};
    vecs[5]  = '{3'b001, 16'h7FFE, 4'b1011, 3'd7, 16'h0000,  0, 16'h0000, 0, 1, 4'b1011, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 16'hFFFF, 4'b0000, 3'd0, 16'h0000,  0, 16'h1357, 1, 2, 4'b1011, 1'b0, 1'b0};
    vecs[7]  = '{3'b010, 16'h0100, 4'b0000, 3'd2, 16'h0000,  3, 16'hA5A5, 4, 5, 4'b1011, 1'b0, 1'b0};
    vecs[8]  = '{3'b011, 16'h0002, 4'b0000, 3'd6, 16'hCAFE,  2, 16'h0000, 3, 3, 4'b1011, 1'b0, 1'b0};
    vecs[9]  = '{3'b010, 16'h0080, 4'b0000, 3'd4, 16'h0000, -1, 16'h0000, 4, 4, 4'b1011, 1'b0, 1'b1};
    vecs[10] = '{3'b000, 16'h0000, 4'b0010, 3'd1, 16'h0000,  0, 16'h0000, 0, 1, 4'b0010, 1'b0, 1'b1};
    vecs[11] = '{3'b101, 16'h5555, 4'b1111, 3'd3, 16'h0000,  0, 16'h0000, 0, 0, 4'b0010, 1'b1, 1'b1};
    vecs[12] = '{3'b111, 16'hAAAA, 4'b1111, 3'd3, 16'h0000,  0, 16'h0000, 0, 0, 4'b0010, 1'b1, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; in_op = 3'b000; in_result = 16'h0; in_flags = 4'h0;
    in_dst_reg = 3'd0; in_store_data = 16'h0; mem_ack = 1'b0; mem_rdata = 16'h0;
    #3;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_flags", 32'(flags_q), 32'd0);
    chk("reset_errs", 32'({err_timeout, err_illegal}), 32'd0);
    chk("reset_req_we", 32'({mem_req, rf_we}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i], rq, bz, il);
      chk($sformatf("v%0d_req_cycles", i), 32'(rq), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bz), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_err_illegal", i), 32'(il), 32'(vecs[i].exp_ill));
      chk($sformatf("v%0d_flags", i), 32'(flags_q), 32'(vecs[i].exp_flags));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_illegal_cleared", i), 32'(err_illegal), 32'd0);
      chk($sformatf("v%0d_err_timeout", i), 32'(err_timeout), 32'(vecs[i].exp_to));
      chk($sformatf("v%0d_rf_drained", i), 32'(rf_q.size()), 32'd0);
    end

    // Reset during the second wait cycle of a load; a late ack afterwards does nothing.
    in_valid = 1'b1; in_op = 3'b010; in_result = 16'h0040; in_dst_reg = 3'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midload_req_before_reset", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midload_req_async_drop", 32'(mem_req), 32'd0);
    chk("midload_in_ready", 32'(in_ready), 32'd1);
    chk("midload_flags_cleared", 32'(flags_q), 32'd0);
    chk("midload_timeout_cleared", 32'(err_timeout), 32'd0);
    chk("midload_outputs_zero", 32'({mem_addr, rf_we, rf_waddr}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'hBEEF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      chk($sformatf("late_ack_idle_%0d", k), 32'({in_ready, mem_req, rf_we}), 32'b100);
    end

    run_op('{3'b000, 16'h4242, 4'b1000, 3'd6, 16'h0000, 0, 16'h0000, 0, 1, 4'b1000, 1'b0, 1'b0},
           rq, bz, il);
    chk("post_reset_add_busy", 32'(bz), 32'd1);
    chk("post_reset_add_flags", 32'(flags_q), 32'b1000);
    @(posedge clk);
    @(negedge clk);
    chk("final_rf_queue_empty", 32'(rf_q.size()), 32'd0);
    chk("final_mem_queue_empty", 32'(mem_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/write-back stage directly downstream of the ALU execute stage. It accepts one executed instruction at a time: ALU op code, 16-bit result, 4-bit flags, destination register and store data. It performs the data-memory access for load/store over a req/ack handshake, writes the register file, and holds the architectural flags register. It also supplies the upstream stall (`in_ready`) and reports memory time-outs and illegal op codes.

## Interface
Parameters:
- `DATA_W`, 16, data/address width
- `REG_AW`, 3, register-file address width (8 registers)
- `TIMEOUT`, 255, max cycles `mem_req` is held without `mem_ack` before abort (1..255)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: stage can accept; equals (state==IDLE).
- `in_op` in 3: 000 add, 001 invert, 010 load, 011 store, 100 nop, 101–111 illegal.
- `in_result` in DATA_W: ALU result; for load/store this is the memory address.
- `in_flags` in 4: bit0 carry, bit1 zero, bit2 negative, bit3 overflow.
- `in_dst_reg` in REG_AW: destination register.
- `in_store_data` in DATA_W: write data for store.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out DATA_W, `mem_wdata` out DATA_W: memory request.
- `mem_ack` in 1, `mem_rdata` in DATA_W: memory response; `mem_rdata` valid when `mem_ack`=1.
- `rf_we` out 1, `rf_waddr` out REG_AW, `rf_wdata` out DATA_W: register-file write port.
- `flags_q` out 4: architectural flags register.
- `err_timeout` out 1: sticky, set on memory abort; cleared only by reset.
- `err_illegal` out 1: one-cycle pulse on accepting op 101–111.

## Operation
- States: IDLE, MEM_RD, MEM_WR, WB.
- Accept = `in_valid` & `in_ready` at a rising edge. All `in_*` fields are latched at accept and are don't-care afterwards.
- IDLE, accept:
  - op 000/001: `flags_q` <= `in_flags`; latch result and dst; go to WB.
  - op 010: latch address and dst; go to MEM_RD.
  - op 011: latch address and data; go to MEM_WR.
  - op 100: consumed, no effect; stay IDLE.
  - op 101–111: treated as nop; `err_illegal` = 1 for the next cycle; stay IDLE.
- MEM_RD: `mem_req`=1, `mem_we`=0, `mem_addr`=latched address.
  - On `mem_ack`: capture `mem_rdata`; go to WB.
- MEM_WR: `mem_req`=1, `mem_we`=1, `mem_addr`/`mem_wdata` latched.
  - On `mem_ack`: go to IDLE. No register write.
- WB: `rf_we`=1, `rf_waddr`=dst, `rf_wdata`=result or read data; go to IDLE.
- `flags_q` is updated only by ops 000/001. Load, store, nop and illegal ops leave it unchanged.
- Time-out counter (8-bit):
  - Cleared on entering MEM_RD/MEM_WR; increments each cycle `mem_req`=1 and `mem_ack`=0.
  - When the count reaches `TIMEOUT` without ack: abort to IDLE, set `err_timeout`, no register write.
  - An ack in the same cycle the count reaches `TIMEOUT` wins; no abort.
- `mem_ack` while `mem_req`=0 is ignored.
- When `mem_req`=0, `mem_we`/`mem_addr`/`mem_wdata` are 0. When `rf_we`=0, `rf_waddr`/`rf_wdata` are 0.

## Timing
- Reset (async, immediate):
  - state IDLE; `flags_q`=0, `err_timeout`=0, `err_illegal`=0.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` = 0; `rf_we`, `rf_waddr`, `rf_wdata` = 0; time-out counter = 0.
  - `in_ready`=1 while reset is held and after release.
- Reset mid-transaction: `mem_req` drops asynchronously, the access is abandoned, and there is no register write.
- Add/invert accepted at edge N:
  - `flags_q` valid after N.
  - `rf_we`=1 during cycle N..N+1; `in_ready`=0 in that cycle.
  - Next accept at edge N+2 at the earliest (throughput 1 per 2 cycles).
- Load accepted at edge N:
  - `mem_req` high from after N until the edge where `mem_ack` is sampled high (edge M ≥ N+1).
  - `rf_we` high during cycle M..M+1; `in_ready` high again after M+1.
- Store: `mem_req` drops after edge M; `in_ready`=1 in the cycle after M.
- Request stability: address, data and `mem_we` stay stable while `mem_req`=1.
- Zero-wait memory (ack combinationally high at first req cycle): load takes 3 cycles accept-to-accept, store takes 2.

## Test plan
- Reset, then add op with result 0x8001, flags 0b0100, dst 3 -> next cycle `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0x8001; `flags_q`=0b0100; `in_ready`=0 for exactly 1 cycle.
- Load from address 0x0040, memory acks after 3 wait cycles with 0xBEEF, dst 5 -> `mem_req` high 4 cycles with `mem_addr`=0x0040, `mem_we`=0; then one `rf_we` pulse writing 0xBEEF to r5; `flags_q` unchanged.
- Store address 0x1234, data 0x00FF, zero-wait ack -> one-cycle `mem_req`, `mem_we`=1, `mem_wdata`=0x00FF; no `rf_we`; next accept 2 cycles after the first.
- Load with `mem_ack` held 0 and `TIMEOUT`=4 -> `mem_req` high 4 cycles, then IDLE with `err_timeout`=1 (sticky); no `rf_we`; a following add completes normally.
- Op 110 accepted -> `err_illegal` pulses 1 cycle; no `mem_req`, no `rf_we`, `flags_q` unchanged. Op 100 -> no outputs change.
- Assert `rst` mid-load (cycle 2 of the wait) -> `mem_req` falls within the same cycle; all outputs at reset values; a late `mem_ack` after reset causes nothing.
